// File: rtl/unidade_controle_if.sv
// Control-unit bus bundle: processor-side inputs (Run, DIN, GNZ) and all
// register-file / ALU / memory strobes. The control unit uses the slave
// modport; the processor side (datapath or bench) uses the master modport.
interface unidade_controle_if #(
    parameter int n = 16
);
    logic         Run;
    logic [n-1:0] DIN;
    logic         GNZ;
    logic         Done;
    logic         IncrPc;
    logic [7:0]   Rin;
    logic [7:0]   Rout;
    logic         Gout;
    logic         DINout;
    logic         Ain;
    logic         Gin;
    logic         AddSub;
    logic         ADDRin;
    logic         DOUTin;
    logic         W_D;

    modport master (
        output Run, DIN, GNZ,
        input  Done, IncrPc, Rin, Rout, Gout, DINout,
               Ain, Gin, AddSub, ADDRin, DOUTin, W_D
    );

    modport slave (
        input  Run, DIN, GNZ,
        output Done, IncrPc, Rin, Rout, Gout, DINout,
               Ain, Gin, AddSub, ADDRin, DOUTin, W_D
    );
endinterface

// File: rtl/unidade_controle.sv
// Multi-cycle control FSM for the 16-bit simple processor.
// Fetch: T0 puts R7 on the bus into ADDR and bumps the PC, T1 covers memory
// latency, T2 latches the 9-bit instruction (III XXX YYY) into IR.
// Execute: EX1..EX3 sequence the per-opcode strobes; Done marks the last cycle.
// Optional feature: define UNIDADE_CONTROLE_MVNZ_EN to make opcode 110 a
// conditional move (mv when GNZ=1); otherwise 110 is a NOP and GNZ is ignored.
module unidade_controle #(
    parameter int n = 16
) (
    input  logic                 Clock,
    input  logic                 Clear,
    unidade_controle_if.slave    bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_EX1,
        S_EX2,
        S_EX3
    } state_t;

    state_t     state_q;
    logic [8:0] ir_q;
    logic [8:0] ir_d;

    logic [2:0] op;
    logic [7:0] x_oh;
    logic [7:0] y_oh;

    logic       done;
    logic       incr_pc;
    logic [7:0] rin;
    logic [7:0] rout;
    logic       gout;
    logic       dinout;
    logic       ain;
    logic       gin;
    logic       addsub;
    logic       addrin;
    logic       doutin;
    logic       w_d;

    assign ir_d = bus.DIN[n-1 -: 9];
    assign op   = ir_q[8:6];
    assign x_oh = 8'h01 << ir_q[5:3];
    assign y_oh = 8'h01 << ir_q[2:0];

`ifdef UNIDADE_CONTROLE_MVNZ_EN
    logic unused_bits;
    assign unused_bits = ^bus.DIN[n-10:0];
`else
    logic unused_bits;
    assign unused_bits = ^{bus.GNZ, bus.DIN[n-10:0]};
`endif

    // Strobe decode from state and IR; Clear blanks every output in its cycle.
    always_comb begin
        done    = 1'b0;
        incr_pc = 1'b0;
        rin     = '0;
        rout    = '0;
        gout    = 1'b0;
        dinout  = 1'b0;
        ain     = 1'b0;
        gin     = 1'b0;
        addsub  = 1'b0;
        addrin  = 1'b0;
        doutin  = 1'b0;
        w_d     = 1'b0;
        if (!Clear) begin
            case (state_q)
                S_T0: begin
                    rout    = 8'h80;
                    addrin  = 1'b1;
                    incr_pc = 1'b1;
                end
                S_EX1: begin
                    case (op)
                        3'b000: begin
                            rout = y_oh;
                            rin  = x_oh;
                            done = 1'b1;
                        end
                        3'b001: begin
                            rout    = 8'h80;
                            addrin  = 1'b1;
                            incr_pc = 1'b1;
                        end
                        3'b010, 3'b011: begin
                            rout = x_oh;
                            ain  = 1'b1;
                        end
                        3'b100, 3'b101: begin
                            rout   = y_oh;
                            addrin = 1'b1;
                        end
                        3'b110: begin
                            done = 1'b1;
`ifdef UNIDADE_CONTROLE_MVNZ_EN
                            if (bus.GNZ) begin
                                rout = y_oh;
                                rin  = x_oh;
                            end
`endif
                        end
                        default: done = 1'b1;
                    endcase
                end
                S_EX2: begin
                    case (op)
                        3'b010, 3'b011: begin
                            rout   = y_oh;
                            gin    = 1'b1;
                            addsub = op[0];
                        end
                        3'b101: begin
                            rout   = x_oh;
                            doutin = 1'b1;
                            w_d    = 1'b1;
                            done   = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_EX3: begin
                    case (op)
                        3'b001, 3'b100: begin
                            dinout = 1'b1;
                            rin    = x_oh;
                            done   = 1'b1;
                        end
                        3'b010, 3'b011: begin
                            gout = 1'b1;
                            rin  = x_oh;
                            done = 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // State sequencing and IR capture; Run is only looked at in IDLE and Done cycles.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (bus.Run) state_q <= S_T0;
                S_T0:   state_q <= S_T1;
                S_T1:   state_q <= S_T2;
                S_T2: begin
                    ir_q    <= ir_d;
                    state_q <= S_EX1;
                end
                S_EX1: state_q <= done ? (bus.Run ? S_T0 : S_IDLE) : S_EX2;
                S_EX2: state_q <= done ? (bus.Run ? S_T0 : S_IDLE) : S_EX3;
                S_EX3: state_q <= bus.Run ? S_T0 : S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.Done   = done;
    assign bus.IncrPc = incr_pc;
    assign bus.Rin    = rin;
    assign bus.Rout   = rout;
    assign bus.Gout   = gout;
    assign bus.DINout = dinout;
    assign bus.Ain    = ain;
    assign bus.Gin    = gin;
    assign bus.AddSub = addsub;
    assign bus.ADDRin = addrin;
    assign bus.DOUTin = doutin;
    assign bus.W_D    = w_d;

endmodule

// File: tb/tb_unidade_controle.sv
// Scoreboard bench for unidade_controle: each scenario pushes per-cycle
// stimulus plus the strobe pattern expected in that cycle, then a runner
// applies and pops them one clock at a time.
module tb_unidade_controle;

`ifdef UNIDADE_CONTROLE_MVNZ_EN
    localparam bit MVNZ_EN = 1'b1;
`else
    localparam bit MVNZ_EN = 1'b0;
`endif

    typedef struct packed {
        logic       done;
        logic       incr;
        logic [7:0] rin;
        logic [7:0] rout;
        logic       gout;
        logic       dinout;
        logic       ain;
        logic       gin;
        logic       addsub;
        logic       addrin;
        logic       doutin;
        logic       wd;
    } outs_t;

    typedef struct {
        logic        run;
        logic        clear;
        logic        gnz;
        logic [15:0] din;
        outs_t       exp;
        string       tag;
    } item_t;

    logic Clock = 1'b0;
    logic Clear;
    int   total = 0;
    int   bad   = 0;

    item_t sb[$];
    outs_t cyc[$];

    always #5 Clock = ~Clock;

    unidade_controle_if #(.n(16)) bus ();

    unidade_controle #(.n(16)) dut (
        .Clock (Clock),
        .Clear (Clear),
        .bus   (bus)
    );

    function automatic outs_t sample();
        outs_t o;
        o.done   = bus.Done;
        o.incr   = bus.IncrPc;
        o.rin    = bus.Rin;
        o.rout   = bus.Rout;
        o.gout   = bus.Gout;
        o.dinout = bus.DINout;
        o.ain    = bus.Ain;
        o.gin    = bus.Gin;
        o.addsub = bus.AddSub;
        o.addrin = bus.ADDRin;
        o.doutin = bus.DOUTin;
        o.wd     = bus.W_D;
        return o;
    endfunction

    // Reference cycle list (T0 .. Done) for one instruction word.
    function void gen(input logic [15:0] w, input logic gnz);
        outs_t      o;
        logic [2:0] op;
        logic [7:0] xo;
        logic [7:0] yo;
        op = w[15:13];
        xo = 8'h01 << w[12:10];
        yo = 8'h01 << w[9:7];
        cyc.delete();
        o = '0; o.rout = 8'h80; o.addrin = 1'b1; o.incr = 1'b1;
        cyc.push_back(o);
        o = '0;
        cyc.push_back(o);
        cyc.push_back(o);
        case (op)
            3'd0: begin
                o = '0; o.rout = yo; o.rin = xo; o.done = 1'b1; cyc.push_back(o);
            end
            3'd1: begin
                o = '0; o.rout = 8'h80; o.addrin = 1'b1; o.incr = 1'b1; cyc.push_back(o);
                o = '0; cyc.push_back(o);
                o = '0; o.dinout = 1'b1; o.rin = xo; o.done = 1'b1; cyc.push_back(o);
            end
            3'd2, 3'd3: begin
                o = '0; o.rout = xo; o.ain = 1'b1; cyc.push_back(o);
                o = '0; o.rout = yo; o.gin = 1'b1; o.addsub = (op == 3'd3); cyc.push_back(o);
                o = '0; o.gout = 1'b1; o.rin = xo; o.done = 1'b1; cyc.push_back(o);
            end
            3'd4: begin
                o = '0; o.rout = yo; o.addrin = 1'b1; cyc.push_back(o);
                o = '0; cyc.push_back(o);
                o = '0; o.dinout = 1'b1; o.rin = xo; o.done = 1'b1; cyc.push_back(o);
            end
            3'd5: begin
                o = '0; o.rout = yo; o.addrin = 1'b1; cyc.push_back(o);
                o = '0; o.rout = xo; o.doutin = 1'b1; o.wd = 1'b1; o.done = 1'b1; cyc.push_back(o);
            end
            3'd6: begin
                o = '0; o.done = 1'b1;
                if (MVNZ_EN && gnz) begin
                    o.rout = yo; o.rin = xo;
                end
                cyc.push_back(o);
            end
            default: begin
                o = '0; o.done = 1'b1; cyc.push_back(o);
            end
        endcase
    endfunction

    task automatic push(input logic run, input logic clr, input logic gnz,
                        input logic [15:0] din, input outs_t e, input string tag);
        item_t it;
        it.run = run; it.clear = clr; it.gnz = gnz; it.din = din; it.exp = e; it.tag = tag;
        sb.push_back(it);
    endtask

    task automatic push_idle(input logic run, input int cnt, input string tag);
        for (int i = 0; i < cnt; i++) push(run, 1'b0, 1'b0, 16'h0000, '0, tag);
    endtask

    task automatic push_instr(input logic [15:0] w, input logic [15:0] imm, input logic gnz,
                              input logic run_mid, input logic run_done, input string tag);
        gen(w, gnz);
        for (int i = 0; i < cyc.size(); i++)
            push((i == cyc.size() - 1) ? run_done : run_mid, 1'b0, gnz,
                 (i <= 2) ? w : imm, cyc[i], $sformatf("%s.c%0d", tag, i));
    endtask

    // Applies queued stimulus one cycle at a time; compares at the falling edge.
    task automatic run_sb(output int incr_cnt, output int done_cnt, output int lat);
        item_t it;
        outs_t obs;
        int    idx;
        int    first_incr;
        incr_cnt = 0; done_cnt = 0; lat = -1; idx = 0; first_incr = -1;
        while (sb.size() > 0) begin
            it = sb.pop_front();
            bus.Run = it.run; Clear = it.clear; bus.GNZ = it.gnz; bus.DIN = it.din;
            @(negedge Clock);
            obs = sample();
            total++;
            if (obs !== it.exp) begin
                bad++;
                $display("FAIL %s: outputs got %h expected %h", it.tag, obs, it.exp);
            end
            total++;
            if ($countones({obs.rout, obs.gout, obs.dinout}) > 1) begin
                bad++;
                $display("FAIL %s bus_sources: got %0d expected <=1", it.tag,
                         $countones({obs.rout, obs.gout, obs.dinout}));
            end
            total++;
            if (obs.incr && obs.rin[7]) begin
                bad++;
                $display("FAIL %s incr_vs_r7: got 1 expected 0", it.tag);
            end
            if (obs.incr === 1'b1) begin
                incr_cnt++;
                if (first_incr < 0) first_incr = idx;
            end
            if (obs.done === 1'b1) begin
                done_cnt++;
                if (lat < 0 && first_incr >= 0) lat = idx - first_incr + 1;
            end
            idx++;
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        int ic, dc, lt;
        push(1'b1, 1'b1, 1'b0, 16'h2000, '0, "reset.clr0");
        push(1'b1, 1'b1, 1'b0, 16'h2000, '0, "reset.clr1");
        push_idle(1'b0, 3, "reset.idle");
        run_sb(ic, dc, lt);
        check_int("reset.incr", ic, 0);
    endtask

    task automatic test_mvi();
        int ic, dc, lt;
        push_idle(1'b1, 1, "mvi.start");
        run_sb(ic, dc, lt);
        push_instr(16'h2000, 16'h0005, 1'b0, 1'b1, 1'b0, "mvi");
        run_sb(ic, dc, lt);
        check_int("mvi.incr_pulses", ic, 2);
        check_int("mvi.latency", lt, 6);
        check_int("mvi.done_count", dc, 1);
        push_idle(1'b0, 2, "mvi.after");
        run_sb(ic, dc, lt);
    endtask

    task automatic test_addsub();
        int ic, dc, lt;
        push_idle(1'b1, 1, "add.start");
        run_sb(ic, dc, lt);
        push_instr(16'h4500, 16'h1234, 1'b0, 1'b1, 1'b1, "add");
        run_sb(ic, dc, lt);
        check_int("add.latency", lt, 6);
        push_instr(16'h6500, 16'h1234, 1'b0, 1'b0, 1'b0, "sub");
        run_sb(ic, dc, lt);
        check_int("sub.latency", lt, 6);
    endtask

    task automatic test_st();
        int ic, dc, lt;
        push_idle(1'b1, 1, "st.start");
        run_sb(ic, dc, lt);
        push_instr(16'hAE00, 16'hFFFF, 1'b0, 1'b1, 1'b0, "st");
        run_sb(ic, dc, lt);
        check_int("st.latency", lt, 5);
    endtask

    task automatic test_mvnz();
        int ic, dc, lt;
        push_idle(1'b1, 1, "mvnz.start");
        run_sb(ic, dc, lt);
        push_instr(16'hDC80, 16'h0000, 1'b1, 1'b1, 1'b1, "mvnz_gnz1");
        run_sb(ic, dc, lt);
        check_int("mvnz.latency", lt, 4);
        push_instr(16'hDC80, 16'h0000, 1'b0, 1'b1, 1'b0, "mvnz_gnz0");
        run_sb(ic, dc, lt);
    endtask

    task automatic test_back_to_back();
        int ic, dc, lt;
        push_idle(1'b1, 1, "b2b.start");
        run_sb(ic, dc, lt);
        push_instr(16'h0E80, 16'h0000, 1'b1, 1'b1, 1'b1, "mv_r7");
        push_instr(16'h9700, 16'hBEEF, 1'b0, 1'b0, 1'b1, "ld_runlow");
        push_instr(16'hE000, 16'h0000, 1'b1, 1'b1, 1'b0, "nop");
        run_sb(ic, dc, lt);
        check_int("b2b.done_count", dc, 3);
        check_int("b2b.incr_pulses", ic, 3);
    endtask

    task automatic test_clear_mid();
        int ic, dc, lt;
        push_idle(1'b1, 1, "clr.start");
        run_sb(ic, dc, lt);
        gen(16'h4500, 1'b0);
        for (int i = 0; i < 4; i++) push(1'b1, 1'b0, 1'b0, 16'h4500, cyc[i], $sformatf("clr.add.c%0d", i));
        push(1'b1, 1'b1, 1'b0, 16'h4500, '0, "clr.ex2");
        push_idle(1'b1, 1, "clr.idle");
        run_sb(ic, dc, lt);
        check_int("clr.no_done", dc, 0);
        push_instr(16'h6500, 16'h0000, 1'b0, 1'b1, 1'b0, "clr.restart");
        run_sb(ic, dc, lt);
        check_int("clr.restart_done", dc, 1);
    endtask

    task automatic test_run_low_done();
        int ic, dc, lt;
        push_idle(1'b1, 1, "rl.start");
        run_sb(ic, dc, lt);
        push_instr(16'h0E80, 16'h0000, 1'b0, 1'b1, 1'b0, "rl.mv");
        push_idle(1'b0, 4, "rl.idle");
        run_sb(ic, dc, lt);
        push_idle(1'b1, 1, "rl.go");
        push_instr(16'hE000, 16'h0000, 1'b0, 1'b0, 1'b0, "rl.nop");
        push_idle(1'b0, 1, "rl.end");
        run_sb(ic, dc, lt);
        check_int("rl.nop_latency", lt, 4);
    endtask

    initial begin
        Clear   = 1'b1;
        bus.Run = 1'b0;
        bus.GNZ = 1'b0;
        bus.DIN = 16'h0000;
        test_reset();
        test_mvi();
        test_addsub();
        test_st();
        test_mvnz();
        test_back_to_back();
        test_clear_mid();
        test_run_low_done();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
